// File: rtl/ext_ram_pkg.sv
// ext_ram_pkg: default geometry and shared word/address types for the
// LDPC working-data RAM.
package ext_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] ldpc_word_t;
    typedef logic [DEFAULT_ADDR_WIDTH-1:0] ldpc_addr_t;

endpackage : ext_ram_pkg

// File: rtl/ext_ram_array.sv
// ext_ram_array: plain storage, synchronous write, asynchronous read.
// The array is never reset; validity is tracked by the parent.
module ext_ram_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    // Store the write word on the rising edge; caller guarantees addr_i is in range.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Zero-latency read of the addressed word.
    assign rdata_o = mem_q[addr_i];

endmodule : ext_ram_array

// File: rtl/ext_ram.sv
// ext_ram: single-port buffer for LDPC decoder LLRs/messages.
// A per-word valid map, cleared asynchronously by rst_n, makes the RAM
// read as all-zero after reset without touching the storage array.
module ext_ram
    import ext_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    input  logic                  chip_sel,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic                  in_range;
    logic                  wr_fire;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] array_rdata;
    logic [RAM_DEPTH-1:0]  valid_q;
    logic [RAM_DEPTH-1:0]  valid_d;

    // No wrap-around: addresses at or beyond RAM_DEPTH are rejected.
    assign in_range = ({1'b0, address} < (ADDR_WIDTH + 1)'(RAM_DEPTH));

    // A held-low rst_n blocks the write, so reset always wins over a same-cycle write.
    assign wr_fire = rst_n & chip_sel & write_en & in_range;

    ext_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (wr_fire),
        .addr_i  (address),
        .wdata_i (data_in),
        .rdata_o (array_rdata)
    );

    // Next valid map: mark the written word valid.
    always_comb begin
        valid_d = valid_q;
        if (wr_fire) begin
            valid_d[address] = 1'b1;
        end
    end

    // Valid map flops, cleared immediately by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Output gating: only a selected, in-range, written word is visible.
    always_comb begin
        rd_hit   = rst_n & chip_sel & in_range;
        data_out = '0;
        if (rd_hit && valid_q[address]) begin
            data_out = array_rdata;
        end
    end

endmodule : ext_ram

// File: tb/tb_ext_ram.sv
// tb_ext_ram: directed and random checks of ext_ram against an array
// scoreboard that follows the memory rules directly.
module tb_ext_ram;
    import ext_ram_pkg::*;

    logic       clk;
    logic       rst_n;
    ldpc_addr_t address;
    ldpc_word_t data_in;
    logic       write_en;
    logic       chip_sel;
    ldpc_word_t data_out;

    int checks = 0;
    int errors = 0;

    ext_ram #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .RAM_DEPTH  (256)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_in  (data_in),
        .write_en (write_en),
        .chip_sel (chip_sel),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: what has been written since the last reset.
    ldpc_word_t m_mem   [256];
    bit         m_valid [256];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m_valid[i] <= 1'b0;
        end else if (chip_sel && write_en) begin
            m_mem[address]   <= data_in;
            m_valid[address] <= 1'b1;
        end
    end

    function automatic ldpc_word_t model_out();
        if (rst_n && chip_sel && m_valid[address]) return m_mem[address];
        return '0;
    endfunction

    task automatic chk(input string name, input ldpc_word_t act, input ldpc_word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h (t=%0t addr=%0d)", name, act, exp, $time, address);
        end
    endtask

    // Cycle-by-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        chk("model", data_out, model_out());
    end

    // Protocol: address and write_en must be known while selected.
    always @(posedge clk) begin
        if (chip_sel === 1'b1) begin
            assert (!$isunknown({address, write_en}))
            else $error("protocol: X on address/write_en while chip_sel=1");
        end
    end

    // Drive a new input set just after the falling edge.
    task automatic drive(input logic cs, input logic we, input ldpc_addr_t a, input ldpc_word_t d);
        @(negedge clk);
        #1;
        chip_sel = cs;
        write_en = we;
        address  = a;
        data_in  = d;
    endtask

    // Hand-computed combinational check, still before the next rising edge.
    task automatic peek(input string name, input ldpc_word_t exp);
        #1;
        chk(name, data_out, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        chip_sel = 1'b0;
        write_en = 1'b0;
        address  = '0;
        data_in  = '0;
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_mem[i]   = '0;
        end
        #2;
        chk("reset out", data_out, 8'd0);
        #20;
        rst_n = 1'b1;

        // 1: two writes, then combinational readback
        drive(1'b1, 1'b1, 8'd0, 8'd75);
        peek("t1 addr0 before write", 8'd0);
        drive(1'b1, 1'b1, 8'd1, 8'd13);
        peek("t1 addr1 before write", 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        peek("t1 read addr0", 8'd75);
        address = 8'd1;
        peek("t1 read addr1", 8'd13);

        // 2: overwrite, old word visible until the edge
        drive(1'b1, 1'b1, 8'd0, 8'd24);
        peek("t2 before edge", 8'd75);
        @(posedge clk);
        peek("t2 after edge", 8'd24);
        drive(1'b1, 1'b0, 8'd1, 8'd0);
        peek("t2 addr1 kept", 8'd13);

        // 3: deselected write is blocked
        drive(1'b0, 1'b1, 8'd1, 8'd99);
        peek("t3 deselected", 8'd0);
        drive(1'b1, 1'b0, 8'd1, 8'd0);
        peek("t3 addr1 kept", 8'd13);

        // 4: async reset mid-cycle, write under reset ignored
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        peek("t4 before reset", 8'd24);
        rst_n = 1'b0;
        peek("t4 in reset", 8'd0);
        drive(1'b1, 1'b1, 8'd2, 8'd77);
        peek("t4 write in reset", 8'd0);
        drive(1'b1, 1'b0, 8'd2, 8'd0);
        rst_n = 1'b1;
        peek("t4 addr2 ignored", 8'd0);
        address = 8'd0;
        peek("t4 addr0 cleared", 8'd0);
        address = 8'd1;
        peek("t4 addr1 cleared", 8'd0);

        // 5: top/bottom address, no aliasing
        drive(1'b1, 1'b1, 8'd255, 8'hA5);
        drive(1'b1, 1'b1, 8'd0, 8'h5A);
        drive(1'b1, 1'b0, 8'd255, 8'd0);
        peek("t5 addr255", 8'hA5);
        address = 8'd0;
        peek("t5 addr0", 8'h5A);
        address = 8'd128;
        peek("t5 addr128 untouched", 8'd0);

        // 6: random traffic with occasional async resets
        for (int n = 0; n < 1000; n++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)));
            peek("rnd comb", model_out());
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                peek("rnd in reset", 8'd0);
                rst_n = 1'b1;
            end
        end

        drive(1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ext_ram
